// File: rtl/byte_mem_sequencer_if.sv
// byte_mem_sequencer_if: pipeline request/ack fields plus single-port data memory bus
interface byte_mem_sequencer_if #(parameter int ADDR_WIDTH = 32);
  logic                  Req;
  logic                  MemWriteReq;
  logic                  ByteOpReq;
  logic [ADDR_WIDTH-1:0] AddrReq;
  logic [31:0]           WDataReq;
  logic                  Ack;
  logic [31:0]           RDataOut;
  logic                  Busy;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemRE;
  logic                  MemWE;
  logic [31:0]           MemWData;
  logic [31:0]           MemRData;
  modport slave (
    input  Req, MemWriteReq, ByteOpReq, AddrReq, WDataReq, MemRData,
    output Ack, RDataOut, Busy, MemAddr, MemRE, MemWE, MemWData
  );
  modport master (
    output Req, MemWriteReq, ByteOpReq, AddrReq, WDataReq, MemRData,
    input  Ack, RDataOut, Busy, MemAddr, MemRE, MemWE, MemWData
  );
endinterface

// File: rtl/byte_mem_sequencer.sv
// byte_mem_sequencer: M-stage load/store sequencer with byte loads and read-modify-write byte stores
module byte_mem_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  byte_mem_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;
  state_t                state;
  logic                  op_we, op_byte, ack, busy, mem_re, mem_we;
  logic [ADDR_WIDTH-1:0] addr, mem_addr;
  logic [31:0]           wdata, mem_wdata, merged;
  logic [7:0]            lane;
  logic [4:0]            sh;
  assign sh     = {addr[1:0], 3'b000};
  assign lane   = 8'(bus.MemRData >> sh);
  assign merged = (bus.MemRData & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh);
  assign bus.Ack      = ack;
  assign bus.Busy     = busy;
  assign bus.MemRE    = mem_re;
  assign bus.MemWE    = mem_we;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWData = mem_wdata;
  // read data arrives the cycle after MemRE, so the load result is steered straight from memory in RDW
  assign bus.RDataOut = (state == RDW && !op_we) ? (op_byte ? {24'b0, lane} : bus.MemRData) : 32'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      op_byte   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack    <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: if (bus.Req) begin
          op_we    <= bus.MemWriteReq;
          op_byte  <= bus.ByteOpReq;
          addr     <= bus.AddrReq;
          wdata    <= bus.WDataReq;
          busy     <= 1'b1;
          mem_addr <= {bus.AddrReq[ADDR_WIDTH-1:2], 2'b00};
          if (bus.MemWriteReq && !bus.ByteOpReq) begin
            state     <= WR;
            mem_we    <= 1'b1;
            mem_wdata <= bus.WDataReq;
            ack       <= 1'b1;
          end else begin
            state  <= RD;
            mem_re <= 1'b1;
          end
        end
        RD: begin
          state <= RDW;
          ack   <= !op_we;
        end
        RDW: if (op_we) begin
          state     <= WR;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
          ack       <= 1'b1;
        end else begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= '0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_byte_mem_sequencer.sv
// tb_byte_mem_sequencer: scoreboard bench with a behavioural 1-cycle-latency memory
module tb_byte_mem_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  byte_mem_sequencer_if #(.ADDR_WIDTH(32)) bus();
  byte_mem_sequencer #(.ADDR_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] rdata; int lat;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          re_cnt = 0, we_cnt = 0, re_cyc = 0, we_cyc = 0, acc_cyc = 0;
  logic [31:0] re_addr = 0, we_addr = 0, we_data = 0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'hDDCCBBAA;
    bus.MemRData = 32'h0;
    forever begin
      @(posedge clk);
      if (bus.MemRE) bus.MemRData <= mem[bus.MemAddr[9:2]];
      if (bus.MemWE) mem[bus.MemAddr[9:2]] <= bus.MemWData;
    end
  end
  always @(negedge clk) begin
    if (bus.MemRE) begin
      re_cnt++;
      re_addr = bus.MemAddr;
      re_cyc = cyc;
    end
    if (bus.MemWE) begin
      we_cnt++;
      we_addr = bus.MemAddr;
      we_data = bus.MemWData;
      we_cyc = cyc;
    end
  end
  function automatic logic [31:0] put_lane(logic [31:0] w, logic [1:0] l, logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*l +: 8] = b;
    return r;
  endfunction
  task automatic drive_req(input logic we, input logic by, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    w = ref_mem[a[9:2]];
    if (!we) begin
      e.rdata = by ? {24'b0, w[8*a[1:0] +: 8]} : w;
      e.lat = 2;
    end else if (!by) begin
      e.rdata = 32'h0;
      e.lat = 1;
      ref_mem[a[9:2]] = wd;
    end else begin
      e.rdata = 32'h0;
      e.lat = 3;
      ref_mem[a[9:2]] = put_lane(w, a[1:0], wd[7:0]);
    end
    exp_q.push_back(e);
    bus.Req = 1'b1;
    bus.MemWriteReq = we;
    bus.ByteOpReq = by;
    bus.AddrReq = a;
    bus.WDataReq = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.Req = 1'b0;
  endtask
  task automatic wait_ack(output int lat, output logic [31:0] rd, output exp_t e);
    lat = 0;
    rd = 32'hx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.Ack) begin
        lat = i;
        rd = bus.RDataOut;
        break;
      end
    end
    if (exp_q.size() == 0) begin
      e.rdata = 32'hDEADBEEF;
      e.lat = -1;
    end else e = exp_q.pop_front();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [133:0] outs;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {bus.Ack, bus.Busy, bus.MemRE, bus.MemWE, bus.MemAddr, bus.MemWData, bus.RDataOut};
    checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else passes++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    outs = {bus.Ack, bus.Busy, bus.MemRE, bus.MemWE, bus.MemAddr, bus.MemWData, bus.RDataOut};
    checks++;
    if (outs !== '0) $display("FAIL idle_outputs: got %h expected 0", outs);
    else passes++;
  endtask
  task automatic test_byte_loads;
    int          lat, w0;
    logic [31:0] rd;
    exp_t        e;
    logic [31:0] want [4] = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
    for (int i = 0; i < 4; i++) begin
      w0 = we_cnt;
      drive_req(1'b0, 1'b1, 32'h100 + i, 32'h0);
      wait_ack(lat, rd, e);
      checks++;
      if (lat !== e.lat) $display("FAIL byte_load_lat[%0d]: got %0d expected %0d", i, lat, e.lat);
      else passes++;
      checks++;
      if (rd !== e.rdata || rd !== want[i]) $display("FAIL byte_load_data[%0d]: got %h expected %h", i, rd, want[i]);
      else passes++;
      checks++;
      if (re_addr !== 32'h100) $display("FAIL byte_load_addr[%0d]: got %h expected 00000100", i, re_addr);
      else passes++;
      checks++;
      if (we_cnt !== w0) $display("FAIL byte_load_we[%0d]: got %0d expected %0d", i, we_cnt, w0);
      else passes++;
    end
  endtask
  task automatic test_byte_store;
    int          lat, w0, r0;
    logic [31:0] rd;
    exp_t        e;
    w0 = we_cnt;
    r0 = re_cnt;
    drive_req(1'b1, 1'b1, 32'h102, 32'hFFFFFF55);
    wait_ack(lat, rd, e);
    checks++;
    if (lat !== 3 || e.lat !== 3) $display("FAIL bstore_lat: got %0d expected 3", lat);
    else passes++;
    checks++;
    if (re_cnt - r0 !== 1 || re_cyc - acc_cyc + 1 !== 1) $display("FAIL bstore_re: got cnt %0d rel %0d expected 1 1", re_cnt - r0, re_cyc - acc_cyc + 1);
    else passes++;
    checks++;
    if (we_cnt - w0 !== 1 || we_cyc - acc_cyc + 1 !== 3) $display("FAIL bstore_we: got cnt %0d rel %0d expected 1 3", we_cnt - w0, we_cyc - acc_cyc + 1);
    else passes++;
    checks++;
    if (we_data !== 32'hDD55BBAA || we_addr !== 32'h100) $display("FAIL bstore_wdata: got %h@%h expected dd55bbaa@00000100", we_data, we_addr);
    else passes++;
    checks++;
    if (rd !== e.rdata) $display("FAIL bstore_rdata: got %h expected %h", rd, e.rdata);
    else passes++;
    drive_req(1'b0, 1'b0, 32'h100, 32'h0);
    wait_ack(lat, rd, e);
    checks++;
    if (rd !== e.rdata || rd !== 32'hDD55BBAA) $display("FAIL bstore_readback: got %h expected dd55bbaa", rd);
    else passes++;
  endtask
  task automatic test_back_to_back;
    int          lat, w0;
    logic [31:0] rd;
    exp_t        e;
    w0 = we_cnt;
    ref_mem[65] = 32'h12345678;
    bus.Req = 1'b1;
    bus.MemWriteReq = 1'b1;
    bus.ByteOpReq = 1'b0;
    bus.AddrReq = 32'h104;
    bus.WDataReq = 32'h12345678;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({bus.Ack, bus.MemWE, bus.RDataOut} !== {2'b11, 32'h0}) $display("FAIL b2b_store_ack: got %b%b %h expected 11 0", bus.Ack, bus.MemWE, bus.RDataOut);
    else passes++;
    @(posedge clk);
    #1;
    bus.MemWriteReq = 1'b0;
    exp_q.push_back('{ref_mem[65], 2});
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.Ack !== 1'b0) $display("FAIL b2b_idle: got busy %b ack %b expected 0 0", bus.Busy, bus.Ack);
    else passes++;
    @(posedge clk);
    #1;
    bus.Req = 1'b0;
    checks++;
    if (bus.Busy !== 1'b1 || bus.MemRE !== 1'b1) $display("FAIL b2b_accept: got busy %b re %b expected 1 1", bus.Busy, bus.MemRE);
    else passes++;
    wait_ack(lat, rd, e);
    checks++;
    if (lat !== e.lat) $display("FAIL b2b_load_lat: got %0d expected %0d", lat, e.lat);
    else passes++;
    checks++;
    if (rd !== 32'h12345678 || rd !== e.rdata) $display("FAIL b2b_load_data: got %h expected 12345678", rd);
    else passes++;
    checks++;
    if (we_cnt - w0 !== 1) $display("FAIL b2b_we_count: got %0d expected 1", we_cnt - w0);
    else passes++;
  endtask
  task automatic test_misaligned;
    int          lat;
    logic [31:0] rd;
    exp_t        e;
    drive_req(1'b0, 1'b0, 32'h107, 32'h0);
    wait_ack(lat, rd, e);
    checks++;
    if (re_addr !== 32'h104) $display("FAIL misaligned_addr: got %h expected 00000104", re_addr);
    else passes++;
    checks++;
    if (rd !== e.rdata) $display("FAIL misaligned_data: got %h expected %h", rd, e.rdata);
    else passes++;
  endtask
  task automatic test_reset_abort;
    int          lat, w0;
    logic [31:0] rd;
    exp_t        e;
    logic        ack_seen, busy_seen;
    w0 = we_cnt;
    ack_seen = 1'b0;
    busy_seen = 1'b0;
    bus.Req = 1'b1;
    bus.MemWriteReq = 1'b1;
    bus.ByteOpReq = 1'b1;
    bus.AddrReq = 32'h101;
    bus.WDataReq = 32'h00000077;
    @(posedge clk);
    #1;
    bus.Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b1) $display("FAIL abort_busy_rdw: got %b expected 1", bus.Busy);
    else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seen |= bus.Ack;
      busy_seen |= bus.Busy;
    end
    checks++;
    if (ack_seen !== 1'b0 || busy_seen !== 1'b0) $display("FAIL abort_quiet: got ack %b busy %b expected 0 0", ack_seen, busy_seen);
    else passes++;
    checks++;
    if (we_cnt !== w0) $display("FAIL abort_we: got %0d expected %0d", we_cnt, w0);
    else passes++;
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'h100, 32'h0);
    wait_ack(lat, rd, e);
    checks++;
    if (rd !== e.rdata || rd !== 32'hDD55BBAA) $display("FAIL abort_mem_unchanged: got %h expected dd55bbaa", rd);
    else passes++;
  endtask
  task automatic test_req_drop;
    int          lat, r0;
    logic [31:0] rd;
    exp_t        e;
    logic        busy_seen;
    busy_seen = 1'b0;
    drive_req(1'b0, 1'b0, 32'h104, 32'h0);
    wait_ack(lat, rd, e);
    checks++;
    if (lat !== 2 || rd !== e.rdata) $display("FAIL req_drop_complete: got lat %0d data %h expected 2 %h", lat, rd, e.rdata);
    else passes++;
    r0 = re_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      busy_seen |= bus.Busy;
    end
    checks++;
    if (busy_seen !== 1'b0 || re_cnt !== r0) $display("FAIL req_drop_no_accept: got busy %b re %0d expected 0 %0d", busy_seen, re_cnt - r0, 0);
    else passes++;
  endtask
  initial begin
    reset = 1'b1;
    bus.Req = 1'b0;
    bus.MemWriteReq = 1'b0;
    bus.ByteOpReq = 1'b0;
    bus.AddrReq = 32'h0;
    bus.WDataReq = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_mem[64] = 32'hDDCCBBAA;
    test_reset;
    @(posedge clk);
    #1;
    test_byte_loads;
    test_byte_store;
    test_back_to_back;
    test_misaligned;
    test_reset_abort;
    test_req_drop;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
